register_file_write_bank: RTL
=============================

Name: register_file_write_bank

Overview:
- Write side of the 32-entry RISC-V integer register file; complements the combinational 32:1 read-port muxes.
- Decodes the write-back address into a one-hot enable, stores Write_Data into one of 32 N-bit registers on the clock edge, and keeps x0 hardwired to zero.
- Exports all register contents to the read muxes.
- Also provides write-tracking state (dirty mask, last-write record, commit counter, x0-write flag) for the debug/trace path.

Parameters:
N, 32, data width of each register.
CNT_W, 16, width of the saturating commit counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous active-low reset.
Reg_Write  input  1  write-back enable from control unit.
Write_Register  input  5  destination register index (rd).
Write_Data  input  N  write-back value.
Clear_Dirty  input  1  clears Dirty_Mask (synchronous).
Write_Enable  output  32  combinational one-hot decode of the write this cycle (bit 0 never set).
Reg_Array  output  32*N  registered contents; Reg_Array[i*N +: N] = x[i]; x0 slice constant 0.
Dirty_Mask  output  32  bit i set once x[i] is written since reset/clear; bit 0 constant 0.
Last_Write_Register  output  5  index of most recent committed write.
Last_Write_Data  output  N  data of most recent committed write.
Commit_Count  output  CNT_W  number of committed writes, saturating.
Zero_Write_Flag  output  1  one-cycle pulse: a write to x0 was attempted last cycle.

Behaviour:
- Reset: on a rising clk with reset=0:
  - x1..x31, Dirty_Mask, Last_Write_Register, Last_Write_Data, Commit_Count and Zero_Write_Flag all go to 0.
  - Reset overrides any concurrent write or clear.
- Commit condition: Reg_Write=1 and Write_Register!=0, sampled at the rising edge with reset=1.
- On commit:
  - x[Write_Register] <= Write_Data.
  - Dirty_Mask[Write_Register] <= 1.
  - Last_Write_Register and Last_Write_Data <= the write's index and value.
  - Commit_Count increments by 1, holding at 2^CNT_W-1.
- Write_Enable:
  - Combinational: bit k = Reg_Write && Write_Register==k, for k=1..31.
  - Bit 0 is always 0; all bits are 0 when Reg_Write=0.
- x0:
  - Has no storage; its Reg_Array slice is tied to 0.
  - Reg_Write=1 with Write_Register=0 changes no register, mask bit, last-write field or counter.
  - Zero_Write_Flag <= 1 for exactly the following cycle; otherwise it is 0.
- Latency:
  - A committed value appears on Reg_Array in the cycle after the edge.
  - There is no internal write-to-read bypass; a same-cycle read of rd returns the old value.
- Clear_Dirty:
  - With no write: Dirty_Mask <= 0 at the edge.
  - With a simultaneous commit: all bits clear except bit Write_Register, which is set (write wins).
- Non-committing cycles: all state holds.
- Back-to-back writes to the same register: each edge takes the new value; Commit_Count counts every write.
- Counter saturation: at 2^CNT_W-1 the counter holds; commits still update registers, mask and last-write fields.
- Reset mid-stream: the write in the reset cycle is discarded; the first write after reset deasserts commits normally.

Test Plan:
- Reset then idle: after reset=0 for 1 cycle, then 3 cycles of Reg_Write=0, require:
  - all 32 Reg_Array slices, Dirty_Mask, Commit_Count, Last_Write_* and Zero_Write_Flag = 0;
  - Write_Enable = 0.
- Basic write/readback: write x5=0xDEADBEEF, then x31=0x12345678, require:
  - Write_Enable = 0x00000020, then 0x80000000;
  - next cycle x5 = 0xDEADBEEF and x31 = 0x12345678;
  - Dirty_Mask = 0x80000020, Commit_Count = 2, Last_Write = (31, 0x12345678).
- x0 write: Reg_Write=1, rd=0, data 0xFFFFFFFF, require:
  - Write_Enable = 0;
  - x0 slice = 0;
  - Zero_Write_Flag = 1 for exactly one cycle;
  - Dirty_Mask, Commit_Count and Last_Write unchanged.
- Clear and write collision: with Dirty_Mask = 0x00000006, assert Clear_Dirty and write x3=7 in the same cycle, require Dirty_Mask = 0x00000008 and x3 = 7.
- Reset overrides write: assert reset=0 while writing x10=0xAA, require:
  - x10 = 0 and Commit_Count = 0;
  - the next write, x10=0xBB with reset=1, gives x10 = 0xBB and Commit_Count = 1.
- Counter saturation: with CNT_W=4, do 20 consecutive writes to x1 with data 1..20, require Commit_Count = 15 after write 15 and thereafter, and x1 = 20.

Source files
------------

// File: rtl/register_file_write_bank.sv
// Write side of the 32-entry RISC-V integer register file: one-hot write decode,
// x1..x31 storage (x0 hardwired to zero) and write-tracking state for debug/trace.
module register_file_write_bank #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Reg_Write,
   input  logic [4:0]         Write_Register,
   input  logic [N-1:0]       Write_Data,
   input  logic               Clear_Dirty,
   output logic [31:0]        Write_Enable,
   output logic [32*N-1:0]    Reg_Array,
   output logic [31:0]        Dirty_Mask,
   output logic [4:0]         Last_Write_Register,
   output logic [N-1:0]       Last_Write_Data,
   output logic [CNT_W-1:0]   Commit_Count,
   output logic               Zero_Write_Flag
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N-1:0]     regs_r [1:31];
   logic [31:0]      we_s;
   logic             commit_s;
   logic             zero_write_s;
   logic [31:0]      dirty_r;
   logic [31:0]      dirty_nxt_s;
   logic [4:0]       last_reg_r;
   logic [N-1:0]     last_data_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             zero_flag_r;
   logic [32*N-1:0]  reg_array_s;

   // One-hot decode of the write-back address; x0 never gets an enable.
   always_comb begin
      we_s = 32'd0;
      for (int k = 1; k < 32; k++) begin
         if (Reg_Write && (Write_Register == 5'(k))) begin
            we_s[k] = 1'b1;
         end else begin
            we_s[k] = 1'b0;
         end
      end
   end

   assign commit_s     = Reg_Write && (Write_Register != 5'd0);
   assign zero_write_s = Reg_Write && (Write_Register == 5'd0);

   // Next-state for the dirty mask and saturating commit counter.
   always_comb begin
      dirty_nxt_s = dirty_r;
      cnt_nxt_s   = cnt_r;
      if (Clear_Dirty) begin
         dirty_nxt_s = 32'd0;
      end else begin
         dirty_nxt_s = dirty_r;
      end
      // A write in the same cycle as a clear keeps its own bit set.
      dirty_nxt_s = dirty_nxt_s | we_s;
      if (commit_s && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Register storage for x1..x31.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 1; k < 32; k++) begin
            regs_r[k] <= '0;
         end
      end else begin
         for (int k = 1; k < 32; k++) begin
            if (we_s[k]) begin
               regs_r[k] <= Write_Data;
            end else begin
               regs_r[k] <= regs_r[k];
            end
         end
      end
   end

   // Write-tracking state: dirty mask, last write, commit count, x0-write pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dirty_r     <= 32'd0;
         last_reg_r  <= 5'd0;
         last_data_r <= '0;
         cnt_r       <= '0;
         zero_flag_r <= 1'b0;
      end else begin
         dirty_r     <= dirty_nxt_s;
         cnt_r       <= cnt_nxt_s;
         zero_flag_r <= zero_write_s;
         if (commit_s) begin
            last_reg_r  <= Write_Register;
            last_data_r <= Write_Data;
         end else begin
            last_reg_r  <= last_reg_r;
            last_data_r <= last_data_r;
         end
      end
   end

   // Flatten storage onto the read-mux bus with the x0 slice tied to zero.
   always_comb begin
      reg_array_s = '0;
      for (int k = 1; k < 32; k++) begin
         reg_array_s[k*N +: N] = regs_r[k];
      end
   end

   assign Write_Enable        = we_s;
   assign Reg_Array           = reg_array_s;
   assign Dirty_Mask          = dirty_r;
   assign Last_Write_Register = last_reg_r;
   assign Last_Write_Data     = last_data_r;
   assign Commit_Count        = cnt_r;
   assign Zero_Write_Flag     = zero_flag_r;

endmodule
